// File: rtl/pconv_pkg.sv
// Shared types, constants and helpers for the pointwise convolution layer.
package pconv_pkg;

  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_REQ  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Largest representable signed n-bit value.
  function automatic longint sat_max(input int unsigned n);
    return (longint'(1) <<< (n - 1)) - longint'(1);
  endfunction

  // Smallest representable signed n-bit value.
  function automatic longint sat_min(input int unsigned n);
    return -(longint'(1) <<< (n - 1));
  endfunction

  // Slice index of weight (o,k) inside the flattened weight bus.
  function automatic int unsigned w_idx(input int unsigned o, input int unsigned k,
                                        input int unsigned in_ch);
    return o * in_ch + k;
  endfunction

endpackage

// File: rtl/pconv_lane.sv
// One output channel: multiply-accumulate, then bias, shift, saturate and optional ReLU.
module pconv_lane
  import pconv_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned RELU  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               req,
  input  logic [N-1:0]       act,
  input  logic [N-1:0]       wgt,
  input  logic [ACC_W-1:0]   bias,
  input  logic [SHIFT_W-1:0] shift,
  output logic [N-1:0]       res
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(N));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(N));

  logic signed [2*N-1:0]   prod_c;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] shr_c;
  logic [N-1:0]            q_c;

  // Product of the current activation/weight pair and the requantised lane result.
  always_comb begin
    prod_c = $signed(act) * $signed(wgt);
    sum_c  = acc + $signed(bias);
    shr_c  = sum_c >>> shift;
    if (shr_c > MAX_V) begin
      q_c = MAX_V[N-1:0];
    end else if (shr_c < MIN_V) begin
      q_c = MIN_V[N-1:0];
    end else begin
      q_c = shr_c[N-1:0];
    end
    if ((RELU != 0) && q_c[N-1]) begin
      q_c = '0;
    end
  end

  // Accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + ACC_W'(prod_c);
      end
      if (req) begin
        res <= q_c;
      end
    end
  end

endmodule

// File: rtl/pconv_layer.sv
// Pointwise (1x1) convolution engine: one pixel in, OUT_CH requantised channels out.
module pconv_layer
  import pconv_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned IN_CH  = 6,
  parameter int unsigned OUT_CH = 32,
  parameter int unsigned PIXELS = 36,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned RELU   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_CH*N-1:0]        in_din,
  input  logic [OUT_CH*IN_CH*N-1:0] weight_din,
  input  logic [OUT_CH*ACC_W-1:0]   bias_din,
  input  logic [OUT_CH*SHIFT_W-1:0] shift_din,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_CH*N-1:0]       out_dout,
  output logic                      frame_end,
  output logic                      busy
);

  localparam int unsigned K_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int unsigned P_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  state_t              state;
  logic [K_W-1:0]      k;
  logic [P_W-1:0]      pix;
  logic [IN_CH*N-1:0]  in_q;
  logic                clr_c;
  logic                en_c;
  logic                req_c;
  logic [N-1:0]        act_c;

  // Lane strobes and the activation selected by the channel counter.
  always_comb begin
    clr_c = (state == S_IDLE) && in_valid;
    en_c  = (state == S_MAC);
    req_c = (state == S_REQ);
    act_c = N'(in_q >> (int'(k) * N));
  end

  // Control FSM, counters and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
      k         <= '0;
      pix       <= '0;
      in_q      <= '0;
    end else begin
      frame_end <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_q     <= in_din;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          if (k == K_W'(IN_CH - 1)) begin
            k     <= '0;
            state <= S_REQ;
          end else begin
            k <= k + K_W'(1);
          end
        end
        S_REQ: begin
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
            if (pix == P_W'(PIXELS - 1)) begin
              pix       <= '0;
              frame_end <= 1'b1;
            end else begin
              pix <= pix + P_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One MAC/requant lane per output channel.
  for (genvar o = 0; o < int'(OUT_CH); o++) begin : g_lane
    logic [N-1:0] wgt_c;

    // Weight (o,k) for the current MAC step.
    always_comb begin
      wgt_c = N'(weight_din >> (w_idx(o, int'(k), IN_CH) * N));
    end

    pconv_lane #(
      .N    (N),
      .ACC_W(ACC_W),
      .RELU (RELU)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_c),
      .en   (en_c),
      .req  (req_c),
      .act  (act_c),
      .wgt  (wgt_c),
      .bias (bias_din[o*ACC_W +: ACC_W]),
      .shift(shift_din[o*SHIFT_W +: SHIFT_W]),
      .res  (out_dout[o*N +: N])
    );
  end

endmodule

// File: tb/tb_pconv_layer.sv
// Bench for pconv_layer: directed and random pixels against an arithmetic reference.
module tb_pconv_layer;

  localparam int N  = 16;
  localparam int IC = 2;
  localparam int OC = 2;
  localparam int PX = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic [IC*N-1:0]   in_din;
  logic [OC*IC*N-1:0] weight_din;
  logic [OC*AW-1:0]  bias_din;
  logic [OC*5-1:0]   shift_din;

  logic              in_ready_a, out_valid_a, frame_end_a, busy_a;
  logic [OC*N-1:0]   dout_a;
  logic              in_ready_b, out_valid_b, frame_end_b, busy_b;
  logic [OC*N-1:0]   dout_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pix_cnt  = 0;

  int w    [OC][IC];
  int bias [OC];
  int sh   [OC];

  pconv_layer #(.N(N), .IN_CH(IC), .OUT_CH(OC), .PIXELS(PX), .ACC_W(AW), .RELU(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_din(in_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_dout(dout_a),
    .frame_end(frame_end_a), .busy(busy_a)
  );

  pconv_layer #(.N(N), .IN_CH(IC), .OUT_CH(OC), .PIXELS(PX), .ACC_W(AW), .RELU(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_din(in_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_dout(dout_b),
    .frame_end(frame_end_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_cfg();
    for (int o = 0; o < OC; o++) begin
      for (int k = 0; k < IC; k++) weight_din[(o*IC+k)*N +: N] = N'(w[o][k]);
      bias_din[o*AW +: AW] = AW'(bias[o]);
      shift_din[o*5 +: 5]  = 5'(sh[o]);
    end
  endtask

  task automatic rand_cfg();
    for (int o = 0; o < OC; o++) begin
      for (int k = 0; k < IC; k++) w[o][k] = $signed(16'($urandom));
      bias[o] = int'($urandom_range(0, 200000)) - 100000;
      sh[o]   = int'($urandom_range(0, 20));
    end
    load_cfg();
  endtask

  // Dot product, wrapping 32-bit bias add, floor shift, clamp, optional ReLU.
  function automatic longint model(input int o, input int a0, input int a1, input bit relu);
    longint acc, t;
    acc = longint'(a0) * w[o][0] + longint'(a1) * w[o][1];
    t   = longint'(int'(acc + longint'(bias[o])));
    t   = t >>> sh[o];
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    if (relu && t < 0) t = 0;
    return t;
  endfunction

  task automatic check_reset_state();
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_dout_b", dout_b, 0);
    check("rst_frame_end", frame_end_a, 0);
    check("rst_busy", busy_a, 0);
  endtask

  // Called just after a falling edge with the DUT idle; returns just after a falling edge.
  task automatic run_pixel(input int a0, input int a1, input int hold);
    logic [OC*N-1:0] held;
    int lat;
    check("in_ready_idle", in_ready_a, 1);
    in_din    = {16'(a1), 16'(a0)};
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        check("frame_end_low", frame_end_a, 0);
        check("busy_high", busy_a, 1);
        check("in_ready_low", in_ready_a, 0);
      end
    end while (!out_valid_a && lat < 20);
    check("latency", lat, IC + 2);
    for (int o = 0; o < OC; o++) begin
      check($sformatf("ch%0d", o), $signed(dout_a[o*N +: N]), model(o, a0, a1, 1'b0));
      check($sformatf("relu_ch%0d", o), $signed(dout_b[o*N +: N]), model(o, a0, a1, 1'b1));
    end
    if (hold > 0) begin
      held     = dout_a;
      in_valid = 1'b1;
      in_din   = (IC*N)'($urandom);
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", out_valid_a, 1);
        check("hold_dout", dout_a, held);
        check("hold_in_ready", in_ready_a, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    pix_cnt++;
    check("out_valid_drop", out_valid_a, 0);
    check("in_ready_back", in_ready_a, 1);
    check("frame_end", frame_end_a, (pix_cnt == PX) ? 1 : 0);
    check("frame_end_relu", frame_end_b, (pix_cnt == PX) ? 1 : 0);
    if (pix_cnt == PX) pix_cnt = 0;
  endtask

  initial begin
    int a0, a1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_din    = '0;
    w[0][0] = 4;    w[0][1] = 5; bias[0] = 6; sh[0] = 1;
    w[1][0] = -100; w[1][1] = 0; bias[1] = 0; sh[1] = 0;
    load_cfg();
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // Basic MAC: ch0=4, ch1=-300 (0 with ReLU).
    run_pixel(3, -2, 0);

    // Floor on a negative odd value: -3 >>> 1 = -2.
    w[0][0] = 1; w[0][1] = 0; bias[0] = 0; sh[0] = 1;
    load_cfg();
    run_pixel(-3, 0, 0);

    // Positive and negative saturation.
    w[0][0] = 32767;  w[0][1] = 32767;  bias[0] = 0; sh[0] = 0;
    w[1][0] = -32767; w[1][1] = -32767; bias[1] = 0; sh[1] = 0;
    load_cfg();
    run_pixel(32767, 32767, 0);

    // Backpressure for 10 cycles; fourth pixel closes the frame.
    rand_cfg();
    run_pixel(1234, -567, 10);

    // Next frame: one pixel, then reset in the MAC phase of the second.
    rand_cfg();
    run_pixel(-20000, 15000, 0);
    in_din   = {16'(7), 16'(9)};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mac_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    pix_cnt = 0;
    @(negedge clk);
    check("post_rst_frame_end", frame_end_a, 0);

    // Random pixels with occasional backpressure; frame_end every fourth.
    for (int i = 0; i < 10; i++) begin
      rand_cfg();
      a0 = $signed(16'($urandom));
      a1 = $signed(16'($urandom));
      run_pixel(a0, a1, (i % 3 == 2) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
